flit_demux: RTL and testbench

- Output-direction counterpart of the one-hot output-port mux.
- Accepts one flit stream from an input port, each flit tagged with a one-hot destination select.
- Buffers flits in an in-order FIFO and steers each to exactly one of PORT_N output ports.
- Enforces per-output, per-VC credit flow control and returns upstream credits as buffer slots free.

---
 rtl/noc_pkg.sv | 20 ++
 rtl/flit_demux.sv | 219 +++++++++++++++++++++
 tb/tb_flit_demux.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC router types and dimensions.
//   PORT_N     - number of router output ports
//   DATAW      - flit payload width
//   VC_NUM     - number of virtual channels carried in the vch field
//   VCH_W      - width of the vch field ($clog2(VC_NUM))
//   router_i_t - one flit on a router link: payload, VC and valid
package noc_pkg;

  localparam int PORT_N = 5;
  localparam int DATAW  = 16;
  localparam int VC_NUM = 2;
  localparam int VCH_W  = 1;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic [VCH_W-1:0] vch;
    logic             valid;
  } router_i_t;

endpackage

// File: rtl/flit_demux.sv
// flit_demux: output-direction flit demultiplexer with credit flow control.
//
// One flit stream enters with a one-hot destination select. Flits are kept
// strictly in order in a small FIFO. The head flit is sent to its output port
// only when that (port, VC) pair holds a credit. Every flit leaving the FIFO
// returns one credit upstream.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   demux_i        in   incoming flit (data, vch, valid)
//   sel            in   one-hot destination port, qualified by demux_i.valid
//   demux_o        out  per-port registered flit outputs
//   credit_i       in   per-(port, VC) credit-return pulses from downstream
//   credit_o_valid out  one-cycle upstream credit pulse
//   credit_o_vch   out  VC of the returned credit
//   err            out  sticky protocol-error flag (cleared only by reset)
module flit_demux
  import noc_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CRED_INIT = 4,
  parameter int VC_N      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  router_i_t                       demux_i,
  input  logic [PORT_N-1:0]               sel,
  output router_i_t [PORT_N-1:0]          demux_o,
  input  logic [PORT_N-1:0][VC_N-1:0]     credit_i,
  output logic                            credit_o_valid,
  output logic [$clog2(VC_N)-1:0]         credit_o_vch,
  output logic                            err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PORT_N);
  localparam int VW = $clog2(VC_N);
  localparam int CW = $clog2(CRED_INIT + 1);

  localparam logic [AW:0]       PTR_ONE  = (AW+1)'(1);
  localparam logic [PORT_N-1:0] SEL_ONE  = PORT_N'(1);
  localparam logic [CW-1:0]     CRED_MAX = CW'(CRED_INIT);
  localparam logic [CW-1:0]     CRED_ONE = CW'(1);

  typedef struct packed {
    logic [DATAW-1:0]  data;
    logic [VW-1:0]     vch;
    logic [PORT_N-1:0] sel;
  } entry_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [PORT_N-1:0] v);
    return (v != '0) && ((v & (v - SEL_ONE)) == '0);
  endfunction

  // Index of the set bit of a one-hot vector (highest set bit otherwise).
  function automatic logic [PW-1:0] onehot_idx(input logic [PORT_N-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < PORT_N; i++) begin
      if (v[i]) begin
        idx = PW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // State
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cred_q [PORT_N][VC_N];
  logic [CW-1:0]   cred_d [PORT_N][VC_N];
  router_i_t [PORT_N-1:0] demux_d, demux_q;
  logic            credit_o_valid_d, credit_o_valid_q;
  logic [VW-1:0]   credit_o_vch_d, credit_o_vch_q;
  logic            err_d, err_q;

  // Head-of-line decode
  entry_t          head_s;
  logic            empty_s, full_s;
  logic            head_ok_s;
  logic [PW-1:0]   head_port_s;
  logic [CW-1:0]   head_cred_s;
  logic            pop_s, push_s, drop_s;
  logic [PORT_N-1:0][VC_N-1:0] dec_s;
  logic            sat_s;

  // Decode the FIFO head and decide push/pop/drop for this cycle.
  always_comb begin
    head_s      = mem_q[rd_ptr_q[AW-1:0]];
    empty_s     = (rd_ptr_q == wr_ptr_q);
    // Same slot index with differing wrap bit means the FIFO is full.
    full_s      = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
                  (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    head_ok_s   = is_onehot(head_s.sel);
    head_port_s = onehot_idx(head_s.sel);
    if (head_ok_s) begin
      head_cred_s = cred_q[head_port_s][head_s.vch];
    end else begin
      head_cred_s = '0;
    end
    // A malformed head is always discarded; a good head waits for a credit.
    pop_s  = !empty_s && (!head_ok_s || (head_cred_s != '0));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push_s = demux_i.valid && (!full_s || pop_s);
    drop_s = demux_i.valid && full_s && !pop_s;
  end

  // FIFO storage and pointer update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{data: demux_i.data, vch: demux_i.vch, sel: sel};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Which (port, VC) counter the current pop consumes.
  always_comb begin
    dec_s = '0;
    for (int p = 0; p < PORT_N; p++) begin
      for (int c = 0; c < VC_N; c++) begin
        dec_s[p][c] = pop_s && head_ok_s &&
                      (head_port_s == PW'(p)) && (head_s.vch == VW'(c));
      end
    end
  end

  // Credit counters: send decrements, credit_i increments, both cancel out.
  always_comb begin
    cred_d = cred_q;
    sat_s  = 1'b0;
    for (int p = 0; p < PORT_N; p++) begin
      for (int c = 0; c < VC_N; c++) begin
        if (credit_i[p][c] && !dec_s[p][c]) begin
          if (cred_q[p][c] == CRED_MAX) begin
            // Downstream returned more credits than it was given.
            sat_s = 1'b1;
          end else begin
            cred_d[p][c] = cred_q[p][c] + CRED_ONE;
          end
        end else if (dec_s[p][c] && !credit_i[p][c]) begin
          cred_d[p][c] = cred_q[p][c] - CRED_ONE;
        end else begin
          cred_d[p][c] = cred_q[p][c];
        end
      end
    end
  end

  // Next-state of the registered outputs and the sticky error flag.
  always_comb begin
    demux_d          = '0;
    credit_o_valid_d = pop_s;
    credit_o_vch_d   = '0;
    if (pop_s) begin
      credit_o_vch_d = head_s.vch;
      if (head_ok_s) begin
        demux_d[head_port_s].data  = head_s.data;
        demux_d[head_port_s].vch   = head_s.vch;
        demux_d[head_port_s].valid = 1'b1;
      end else begin
        demux_d = '0;
      end
    end else begin
      credit_o_vch_d = '0;
    end
    err_d = err_q | drop_s | (pop_s && !head_ok_s) | sat_s;
  end

  // All state registers; reset empties the FIFO and restores every credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int p = 0; p < PORT_N; p++) begin
        for (int c = 0; c < VC_N; c++) begin
          cred_q[p][c] <= CRED_MAX;
        end
      end
      demux_q          <= '0;
      credit_o_valid_q <= 1'b0;
      credit_o_vch_q   <= '0;
      err_q            <= 1'b0;
    end else begin
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      cred_q           <= cred_d;
      demux_q          <= demux_d;
      credit_o_valid_q <= credit_o_valid_d;
      credit_o_vch_q   <= credit_o_vch_d;
      err_q            <= err_d;
    end
  end

  assign demux_o        = demux_q;
  assign credit_o_valid = credit_o_valid_q;
  assign credit_o_vch   = credit_o_vch_q;
  assign err            = err_q;

endmodule

// File: tb/tb_flit_demux.sv
// tb_flit_demux: directed testbench for flit_demux (PORT_N=5, DEPTH=4,
// CRED_INIT=4, VC_N=2). Inputs change on the falling edge, outputs are
// sampled on the falling edge after the capturing rising edge.
module tb_flit_demux;
  import noc_pkg::*;

  logic                        clk;
  logic                        rst_n;
  router_i_t                   demux_i;
  logic [PORT_N-1:0]           sel;
  router_i_t [PORT_N-1:0]      demux_o;
  logic [PORT_N-1:0][1:0]      credit_i;
  logic                        credit_o_valid;
  logic [0:0]                  credit_o_vch;
  logic                        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  flit_demux #(.DEPTH(4), .CRED_INIT(4), .VC_N(2)) dut (
    .clk(clk), .rst_n(rst_n), .demux_i(demux_i), .sel(sel), .demux_o(demux_o),
    .credit_i(credit_i), .credit_o_valid(credit_o_valid),
    .credit_o_vch(credit_o_vch), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic router_i_t mk(input logic [DATAW-1:0] d, input logic v);
    router_i_t r;
    r.data = d; r.vch = v; r.valid = 1'b1;
    return r;
  endfunction

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    demux_i = '0; sel = '0;
  endtask

  task automatic drive_flit(input logic [DATAW-1:0] d, input logic v, input logic [PORT_N-1:0] s);
    demux_i = mk(d, v); sel = s;
  endtask

  task automatic do_reset();
    drive_idle(); credit_i = '0; rst_n = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_reset();
    drive_idle(); credit_i = '0; rst_n = 1'b0;
    nxt(); nxt();
    total_cnt++; if (demux_o !== '0) $display("FAIL reset_demux_o: got %h expected 0", demux_o); else pass_cnt++;
    total_cnt++; if (credit_o_valid !== 1'b0) $display("FAIL reset_credit_valid: got %b expected 0", credit_o_valid); else pass_cnt++;
    total_cnt++; if (credit_o_vch !== 1'b0) $display("FAIL reset_credit_vch: got %b expected 0", credit_o_vch); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else pass_cnt++;
    rst_n = 1'b1;
    nxt();
    for (int p = 0; p < PORT_N; p++) begin
      for (int c = 0; c < 2; c++) begin
        total_cnt++;
        if (dut.cred_q[p][c] !== 3'd4) $display("FAIL reset_cred[%0d][%0d]: got %0d expected 4", p, c, dut.cred_q[p][c]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_single();
    router_i_t [PORT_N-1:0] exp;
    drive_flit(16'h005A, 1'b0, 5'b00100);
    nxt();
    drive_idle();
    total_cnt++; if (demux_o !== '0) $display("FAIL single_early: got %h expected 0", demux_o); else pass_cnt++;
    nxt();
    exp = '0; exp[2] = mk(16'h005A, 1'b0);
    total_cnt++; if (demux_o !== exp) $display("FAIL single_out: got %h expected %h", demux_o, exp); else pass_cnt++;
    total_cnt++; if (credit_o_valid !== 1'b1) $display("FAIL single_credit_valid: got %b expected 1", credit_o_valid); else pass_cnt++;
    total_cnt++; if (credit_o_vch !== 1'b0) $display("FAIL single_credit_vch: got %b expected 0", credit_o_vch); else pass_cnt++;
    nxt();
    total_cnt++; if (demux_o !== '0) $display("FAIL single_clear: got %h expected 0", demux_o); else pass_cnt++;
    total_cnt++; if (credit_o_valid !== 1'b0) $display("FAIL single_credit_clear: got %b expected 0", credit_o_valid); else pass_cnt++;
    total_cnt++; if (dut.cred_q[2][0] !== 3'd3) $display("FAIL single_cred: got %0d expected 3", dut.cred_q[2][0]); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL single_err: got %b expected 0", err); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    router_i_t [PORT_N-1:0] exp;
    logic exp_cv;
    for (int j = 0; j < 10; j++) begin
      if (j < 5) drive_flit(16'h0010 + 16'(j), 1'b1, 5'b00010);
      else drive_idle();
      nxt();
      exp = '0; exp_cv = 1'b0;
      if (j >= 1 && j <= 4) begin
        exp[1] = mk(16'h0010 + 16'(j - 1), 1'b1);
        exp_cv = 1'b1;
      end
      total_cnt++; if (demux_o !== exp) $display("FAIL b2b_out[%0d]: got %h expected %h", j, demux_o, exp); else pass_cnt++;
      total_cnt++; if (credit_o_valid !== exp_cv) $display("FAIL b2b_credit[%0d]: got %b expected %b", j, credit_o_valid, exp_cv); else pass_cnt++;
    end
    credit_i[1][1] = 1'b1;
    nxt();
    credit_i = '0;
    total_cnt++; if (demux_o !== '0) $display("FAIL b2b_wait: got %h expected 0", demux_o); else pass_cnt++;
    nxt();
    exp = '0; exp[1] = mk(16'h0014, 1'b1);
    total_cnt++; if (demux_o !== exp) $display("FAIL b2b_fifth: got %h expected %h", demux_o, exp); else pass_cnt++;
    total_cnt++; if (credit_o_vch !== 1'b1) $display("FAIL b2b_credit_vch: got %b expected 1", credit_o_vch); else pass_cnt++;
    nxt();
    total_cnt++; if (dut.cred_q[1][1] !== 3'd0) $display("FAIL b2b_cred: got %0d expected 0", dut.cred_q[1][1]); else pass_cnt++;
  endtask

  task automatic test_in_order();
    router_i_t [PORT_N-1:0] exp;
    for (int j = 0; j < 13; j++) begin
      credit_i = '0;
      if (j < 5) drive_flit(16'h0020 + 16'(j), 1'b0, 5'b00001);
      else if (j == 5) drive_flit(16'h0030, 1'b0, 5'b01000);
      else drive_idle();
      if (j == 9) credit_i[0][0] = 1'b1;
      nxt();
      exp = '0;
      if (j >= 1 && j <= 4) exp[0] = mk(16'h0020 + 16'(j - 1), 1'b0);
      else if (j == 10) exp[0] = mk(16'h0024, 1'b0);
      else if (j == 11) exp[3] = mk(16'h0030, 1'b0);
      else exp = '0;
      total_cnt++; if (demux_o !== exp) $display("FAIL inorder_out[%0d]: got %h expected %h", j, demux_o, exp); else pass_cnt++;
    end
    credit_i = '0;
  endtask

  task automatic test_bad_sel();
    total_cnt++; if (err !== 1'b0) $display("FAIL badsel_pre_err: got %b expected 0", err); else pass_cnt++;
    drive_flit(16'h0077, 1'b1, 5'b00011);
    nxt();
    drive_idle();
    nxt();
    total_cnt++; if (demux_o !== '0) $display("FAIL badsel_out: got %h expected 0", demux_o); else pass_cnt++;
    total_cnt++; if (credit_o_valid !== 1'b1) $display("FAIL badsel_credit: got %b expected 1", credit_o_valid); else pass_cnt++;
    total_cnt++; if (credit_o_vch !== 1'b1) $display("FAIL badsel_credit_vch: got %b expected 1", credit_o_vch); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL badsel_err: got %b expected 1", err); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [DATAW-1:0] seen [$];
    logic [DATAW-1:0] exp_seq [5];
    int cpulse;
    int wrong_port;
    exp_seq[0] = 16'h0050; exp_seq[1] = 16'h0051; exp_seq[2] = 16'h0052;
    exp_seq[3] = 16'h0053; exp_seq[4] = 16'h0055;
    // Four flits drain cred[3][1], the next four fill the FIFO, the ninth overflows.
    for (int j = 0; j < 9; j++) begin
      if (j < 4) drive_flit(16'h0040 + 16'(j), 1'b1, 5'b01000);
      else drive_flit(16'h0050 + 16'(j - 4), 1'b1, 5'b01000);
      nxt();
      if (j == 7) begin
        total_cnt++; if (err !== 1'b0) $display("FAIL ovf_err_before: got %b expected 0", err); else pass_cnt++;
      end
      if (j == 8) begin
        total_cnt++; if (err !== 1'b1) $display("FAIL ovf_err_after: got %b expected 1", err); else pass_cnt++;
      end
    end
    drive_idle();
    total_cnt++; if (dut.cred_q[3][1] !== 3'd0) $display("FAIL ovf_cred_empty: got %0d expected 0", dut.cred_q[3][1]); else pass_cnt++;
    cpulse = 0; wrong_port = 0;
    for (int k = 0; k < 10; k++) begin
      credit_i = '0;
      if (k < 5) credit_i[3][1] = 1'b1;
      // Pushed while the FIFO is full but popping: must be accepted.
      if (k == 1) drive_flit(16'h0055, 1'b1, 5'b01000);
      else drive_idle();
      nxt();
      for (int p = 0; p < PORT_N; p++) begin
        if (demux_o[p].valid) begin
          seen.push_back(demux_o[p].data);
          if (p != 3) wrong_port++;
        end
      end
      if (credit_o_valid) cpulse++;
    end
    credit_i = '0;
    total_cnt++; if (seen.size() != 5) $display("FAIL ovf_drain_count: got %0d expected 5", seen.size()); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (i >= seen.size() || seen[i] !== exp_seq[i])
        $display("FAIL ovf_drain_data[%0d]: got %h expected %h", i, (i < seen.size()) ? seen[i] : 16'hxxxx, exp_seq[i]);
      else pass_cnt++;
    end
    total_cnt++; if (wrong_port != 0) $display("FAIL ovf_port: got %0d off-port flits expected 0", wrong_port); else pass_cnt++;
    total_cnt++; if (cpulse != 5) $display("FAIL ovf_credit_count: got %0d expected 5", cpulse); else pass_cnt++;
  endtask

  task automatic test_credit_counter();
    router_i_t [PORT_N-1:0] exp;
    drive_flit(16'h0066, 1'b0, 5'b10000);
    nxt();
    drive_idle();
    credit_i[4][0] = 1'b1;
    nxt();
    credit_i = '0;
    exp = '0; exp[4] = mk(16'h0066, 1'b0);
    total_cnt++; if (demux_o !== exp) $display("FAIL cred_same_out: got %h expected %h", demux_o, exp); else pass_cnt++;
    total_cnt++; if (dut.cred_q[4][0] !== 3'd4) $display("FAIL cred_same_cycle: got %0d expected 4", dut.cred_q[4][0]); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL cred_same_err: got %b expected 0", err); else pass_cnt++;
    credit_i[4][0] = 1'b1;
    nxt();
    credit_i = '0;
    total_cnt++; if (err !== 1'b1) $display("FAIL cred_sat_err: got %b expected 1", err); else pass_cnt++;
    total_cnt++; if (dut.cred_q[4][0] !== 3'd4) $display("FAIL cred_sat_value: got %0d expected 4", dut.cred_q[4][0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int stray;
    drive_flit(16'h0070, 1'b0, 5'b00100);
    nxt();
    drive_flit(16'h0071, 1'b0, 5'b00100);
    nxt();
    total_cnt++; if (demux_o[2].valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b expected 1", demux_o[2].valid); else pass_cnt++;
    drive_flit(16'h0072, 1'b0, 5'b00100);
    #2;
    rst_n = 1'b0;
    drive_idle();
    #1;
    total_cnt++; if (demux_o !== '0) $display("FAIL rstmid_out: got %h expected 0", demux_o); else pass_cnt++;
    total_cnt++; if (credit_o_valid !== 1'b0) $display("FAIL rstmid_credit: got %b expected 0", credit_o_valid); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rstmid_err: got %b expected 0", err); else pass_cnt++;
    nxt();
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      nxt();
      if (demux_o !== '0 || credit_o_valid !== 1'b0) stray++;
    end
    total_cnt++; if (stray != 0) $display("FAIL rstmid_discard: got %0d active cycles expected 0", stray); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; drive_idle(); credit_i = '0;
    nxt();
    test_reset();
    test_single();
    test_back_to_back();
    test_in_order();
    test_bad_sel();
    do_reset();
    test_overflow();
    do_reset();
    test_credit_counter();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
